obs_split_mult_60bit: RTL and testbench

OBS_SPLIT_MULT_60BIT -- requirements
Module: obs_split_mult_60bit

---
 rtl/obs_pkg.sv | 14 +
 rtl/gf2_serial_mac.sv | 36 +++
 rtl/obs_split_mult_60bit.sv | 115 +++++++++++
 tb/tb_obs_split_mult_60bit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/obs_pkg.sv
// Shared widths and FSM encoding for the odd/even split carry-less multiplier.
package obs_pkg;

    localparam int N    = 60;
    localparam int HALF = N / 2;
    localparam int PP_W = N - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gf2_serial_mac.sv
// One W x W carry-less multiplier lane: MSB-first shift-and-XOR, one multiplier bit per enabled cycle.
module gf2_serial_mac
    import obs_pkg::*;
#(
    parameter int W = HALF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     mcand,
    input  logic             mbit,
    output logic [2*W-2:0]   acc
);

    logic [2*W-2:0] addend;

    always_comb begin
        addend = '0;
        if (mbit) begin
            addend[W-1:0] = mcand;
        end
    end

    // The shift drops acc's top bit; after W steps the degree never exceeds 2W-2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= {acc[2*W-3:0], 1'b0} ^ addend;
        end
    end

endmodule

// File: rtl/obs_split_mult_60bit.sv
// Odd/even split GF(2) multiplier: four parallel HALF x HALF serial carry-less products for an overlap stage.
module obs_split_mult_60bit
    import obs_pkg::*;
#(
    parameter int N = obs_pkg::N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-2:0]   p_ee,
    output logic [N-2:0]   p_eo,
    output logic [N-2:0]   p_oe,
    output logic [N-2:0]   p_oo
);

    localparam int H  = N / 2;
    localparam int CW = $clog2(H);

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [H-1:0]    ae, ao, be, bo;
    logic [H-1:0]    a_e, a_o, b_e, b_o;
    logic            accept;
    logic            run_en;

    always_comb begin
        a_e = '0;
        a_o = '0;
        b_e = '0;
        b_o = '0;
        for (int k = 0; k < H; k++) begin
            a_e[k] = a[2*k];
            a_o[k] = a[2*k+1];
            b_e[k] = b[2*k];
            b_o[k] = b[2*k+1];
        end
    end

    assign accept = in_valid && in_ready;
    assign run_en = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            ae        <= '0;
            ao        <= '0;
            be        <= '0;
            bo        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ae       <= a_e;
                        ao       <= a_o;
                        be       <= b_e;
                        bo       <= b_o;
                        cnt      <= CW'(H - 1);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // in_ready only rises on the next cycle, so no accept can share this edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    gf2_serial_mac #(.W(H)) u_mac_ee (
        .clk(clk), .rst(rst), .clr(accept), .en(run_en),
        .mcand(ae), .mbit(be[cnt]), .acc(p_ee)
    );

    gf2_serial_mac #(.W(H)) u_mac_eo (
        .clk(clk), .rst(rst), .clr(accept), .en(run_en),
        .mcand(ae), .mbit(bo[cnt]), .acc(p_eo)
    );

    gf2_serial_mac #(.W(H)) u_mac_oe (
        .clk(clk), .rst(rst), .clr(accept), .en(run_en),
        .mcand(ao), .mbit(be[cnt]), .acc(p_oe)
    );

    gf2_serial_mac #(.W(H)) u_mac_oo (
        .clk(clk), .rst(rst), .clr(accept), .en(run_en),
        .mcand(ao), .mbit(bo[cnt]), .acc(p_oo)
    );

endmodule

// File: tb/tb_obs_split_mult_60bit.sv
// Directed-vector and random bench for obs_split_mult_60bit, including an overlap-stage model.
module tb_obs_split_mult_60bit;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [59:0]  a;
    logic [59:0]  b;
    logic         out_valid;
    logic         out_ready;
    logic [58:0]  p_ee, p_eo, p_oe, p_oo;

    int total  = 0;
    int passed = 0;

    obs_split_mult_60bit #(.N(60)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .p_ee(p_ee), .p_eo(p_eo), .p_oe(p_oe), .p_oo(p_oo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [59:0] va;
        logic [59:0] vb;
        logic [59:0] ee;
        logic [59:0] eo;
        logic [59:0] oe;
        logic [59:0] oo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Wait for in_ready, offer one pair, return cycles from acceptance edge to out_valid.
    task automatic do_op(input logic [59:0] av, input logic [59:0] bv, output int lat);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) check("in_ready_timeout", 128'(in_ready), 128'(1));
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    function automatic logic [118:0] combine(input logic [58:0] ee, input logic [58:0] eo,
                                             input logic [58:0] oe, input logic [58:0] oo);
        logic [118:0] r;
        r = '0;
        for (int k = 0; k < 59; k++) begin
            r[2*k]   = r[2*k]   ^ ee[k];
            r[2*k+1] = r[2*k+1] ^ eo[k] ^ oe[k];
            r[2*k+2] = r[2*k+2] ^ oo[k];
        end
        return r;
    endfunction

    function automatic logic [118:0] clmul_ref(input logic [59:0] x, input logic [59:0] y);
        logic [118:0] r;
        r = '0;
        for (int i = 0; i < 60; i++) begin
            if (y[i]) r = r ^ (119'(x) << i);
        end
        return r;
    endfunction

    initial begin
        int           lat;
        int           seen;
        logic [58:0]  h_ee, h_eo, h_oe, h_oo;
        logic [63:0]  ra, rb;

        vecs[0] = '{60'h1, 60'h1, 60'h1, 60'h0, 60'h0, 60'h0};
        vecs[1] = '{60'hFFF_FFFF_FFFF_FFFF, 60'h2, 60'h0, 60'h3FFF_FFFF, 60'h0, 60'h3FFF_FFFF};
        vecs[2] = '{60'h400_0000_0000_0000, 60'h400_0000_0000_0000,
                    60'h400_0000_0000_0000, 60'h0, 60'h0, 60'h0};
        vecs[3] = '{60'h0, 60'h0, 60'h0, 60'h0, 60'h0, 60'h0};
        vecs[4] = '{60'h2, 60'h2, 60'h0, 60'h0, 60'h0, 60'h1};
        vecs[5] = '{60'h3, 60'h3, 60'h1, 60'h1, 60'h1, 60'h1};
        vecs[6] = '{60'hFFF_FFFF_FFFF_FFFF, 60'hFFF_FFFF_FFFF_FFFF,
                    60'h555_5555_5555_5555, 60'h555_5555_5555_5555,
                    60'h555_5555_5555_5555, 60'h555_5555_5555_5555};
        vecs[7] = '{60'hFFF_FFFF_FFFF_FFFF, 60'h1, 60'h3FFF_FFFF, 60'h0, 60'h3FFF_FFFF, 60'h0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_p_ee", 128'(p_ee), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, lat);
            check($sformatf("v%0d_latency", i), 128'(lat), 128'(30));
            check($sformatf("v%0d_p_ee", i), 128'(p_ee), 128'(vecs[i].ee));
            check($sformatf("v%0d_p_eo", i), 128'(p_eo), 128'(vecs[i].eo));
            check($sformatf("v%0d_p_oe", i), 128'(p_oe), 128'(vecs[i].oe));
            check($sformatf("v%0d_p_oo", i), 128'(p_oo), 128'(vecs[i].oo));
            @(posedge clk); #1;
        end

        // Backpressure with in_valid held high during DONE
        out_ready = 1'b0;
        do_op(60'hFFF_FFFF_FFFF_FFFF, 60'h2, lat);
        check("bp_latency", 128'(lat), 128'(30));
        h_ee = p_ee; h_eo = p_eo; h_oe = p_oe; h_oo = p_oo;
        check("bp_p_eo", 128'(p_eo), 128'(59'h3FFF_FFFF));
        for (int i = 0; i < 10; i++) begin
            a = 60'h123_4567_89AB_CDEF;
            b = 60'hFED_CBA9_8765_4321;
            in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp%0d_out_valid", i), 128'(out_valid), 128'(1));
            check($sformatf("bp%0d_in_ready", i), 128'(in_ready), 128'(0));
            check($sformatf("bp%0d_hold", i), 128'({p_ee, p_eo, p_oe, p_oo}) ^ 128'({h_ee, h_eo, h_oe, h_oo}), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_release_out_valid", 128'(out_valid), 128'(0));
        check("bp_release_in_ready", 128'(in_ready), 128'(1));
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_p_eo", 128'(p_eo), 128'(59'h3FFF_FFFF));
        check("idle_hold_p_oo", 128'(p_oo), 128'(59'h3FFF_FFFF));
        check("idle_no_accept", 128'(in_ready), 128'(1));

        // Reset in the middle of RUN
        a = 60'hFFF_FFFF_FFFF_FFFF;
        b = 60'hFFF_FFFF_FFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("mid_run_busy", 128'(in_ready), 128'(0));
        rst = 1'b1;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_p_ee_cleared", 128'(p_ee), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_no_stale", 128'(seen), 128'(0));
        do_op(60'h2, 60'h2, lat);
        check("post_rst_latency", 128'(lat), 128'(30));
        check("post_rst_p_oo", 128'(p_oo), 128'(1));
        check("post_rst_others", 128'({p_ee, p_eo, p_oe}), 128'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            do_op(ra[59:0], rb[59:0], lat);
            check($sformatf("rand%0d", i), 128'(combine(p_ee, p_eo, p_oe, p_oo)),
                  128'(clmul_ref(ra[59:0], rb[59:0])));
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
